mem_axi_master: RTL and testbench
=================================

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 The block SHALL have parameter ID_VAL, default 4'h1, the fixed ARID/AWID value.
REQ-002 The block SHALL provide these ports, one per line (name, direction, width, meaning); clock is ACLK and reset is ARESETn, a single clock with reset asynchronous and active-low.
ACLK  in  1  clock
ARESETn  in  1  async active-low reset
mem_re  in  1  MEM-stage load request (MEM_M[1])
mem_we  in  1  MEM-stage store request (MEM_M[0])
mem_addr  in  32  byte address (MEM_ALU_out)
mem_wdata  in  32  store data (MEM_WriteDatain)
mem_wstrb  in  4  store byte enables
mem_rdata  out  32  load data, registered
mem_stall  out  1  hold EX_MEM and all earlier stages
mem_bus_err  out  1  sticky response error
ARADDR  out  32  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  32  read data
RRESP  in  2  read response
RVALID  in  1  read data valid
RREADY  out  1  read data ready
AWADDR  out  32  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  32  write data
WSTRB  out  4  write strobes
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BRESP  in  2  write response
BVALID  in  1  write response valid
BREADY  out  1  write response ready
REQ-003 ARID/AWID SHALL be ID_VAL; ARLEN/AWLEN SHALL be 0; ARSIZE/AWSIZE SHALL be 3'b010; ARBURST/AWBURST SHALL be 2'b01; WLAST SHALL equal WVALID.

Function
REQ-004 FSM states SHALL be IDLE, RADDR, RDATA_S, WREQ, WRESP, DONE.
REQ-005 IDLE: mem_we=1 -> capture addr/wdata/wstrb, go to WREQ; else mem_re=1 -> capture addr, go to RADDR; mem_we has priority when both are high.
REQ-006 RADDR: ARVALID=1 with the captured address; on ARVALID&ARREADY go to RDATA_S.
REQ-007 RDATA_S: RREADY=1; on RVALID, register RDATA into mem_rdata and go to DONE.
REQ-008 WREQ: AWVALID and WVALID SHALL rise in the same cycle; each SHALL drop independently on its own handshake; go to WRESP once both handshakes are done, including when both occur in the same cycle.
REQ-009 WRESP: BREADY=1; on BVALID go to DONE.
REQ-010 DONE: lasts exactly one cycle, then IDLE; the request SHALL NOT be re-sampled in DONE.
REQ-011 mem_stall SHALL be combinational: 1 in IDLE when (mem_re|mem_we), 1 in RADDR, RDATA_S, WREQ and WRESP, and 0 in DONE.
REQ-012 Every VALID and its payload SHALL stay stable from assertion until its handshake.
REQ-013 Minimum load latency SHALL be request cycle N, ARVALID at N+1, RREADY at N+2, mem_rdata valid and stall low at N+3.
REQ-014 mem_rdata SHALL hold its value until the next read handshake.

Reset
REQ-015 While ARESETn=0: state=IDLE, all VALID/READY outputs=0, captured regs=0, mem_rdata=0, mem_bus_err=0; this applies immediately, including mid-transaction.

Configuration
REQ-016 Macro MEM_AXI_ERR_EN. Defined: RRESP or BRESP != 2'b00 at its handshake sets mem_bus_err, which is cleared only by reset. Undefined: mem_bus_err is constant 0. In both cases the transaction completes normally.

Verification
REQ-017 Load, addr 0x0000_1004, ARREADY=1, RVALID one cycle later with RDATA=0xDEADBEEF -> mem_rdata=0xDEADBEEF at N+3; mem_stall high N..N+2 and low at N+3.
REQ-018 Store, addr 0x2000, wdata 0x12345678, wstrb 4'hF; AWREADY at +1, WREADY at +3, BVALID at +5 -> AWVALID drops after its handshake, WVALID holds until +3, DONE after BVALID.
REQ-019 mem_re=mem_we=1 -> only the AW/W channels activate and ARVALID stays 0.
REQ-020 ARREADY held low 10 cycles -> ARVALID and ARADDR stay stable and mem_stall stays 1 throughout.
REQ-021 BRESP=2'b10 -> mem_bus_err=1 with the macro defined and 0 without it; assert ARESETn=0 mid-WREQ -> all valids 0 and state IDLE.

Source files
------------

// File: rtl/mem_axi_master.sv
// Single-outstanding AXI4 master bridging a pipeline MEM stage to memory; stalls the pipeline until done.
// Define MEM_AXI_ERR_EN to make non-OKAY RRESP/BRESP set the sticky mem_bus_err flag.
module mem_axi_master #(
  parameter logic [3:0] ID_VAL = 4'h1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WREQ, WRESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        err_q, err_d;
  logic        aw_done, w_done;

  // A channel counts as done once its valid has dropped or is handshaking this cycle.
  assign aw_done = !awvalid_q || AWREADY;
  assign w_done  = !wvalid_q  || WREADY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (mem_we) begin
          state_d   = WREQ;
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (mem_re) begin
          state_d   = RADDR;
          addr_d    = mem_addr;
          arvalid_d = 1'b1;
        end
      end
      RADDR: begin
        if (ARREADY) begin
          state_d   = RDATA_S;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA_S: begin
        if (RVALID) begin
          state_d  = DONE;
          rdata_d  = RDATA;
          rready_d = 1'b0;
`ifdef MEM_AXI_ERR_EN
          if (RRESP != 2'b00) err_d = 1'b1;
`endif
        end
      end
      WREQ: begin
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (BVALID) begin
          state_d  = DONE;
          bready_d = 1'b0;
`ifdef MEM_AXI_ERR_EN
          if (BRESP != 2'b00) err_d = 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifndef MEM_AXI_ERR_EN
  logic unused_resp;
  assign unused_resp = ^{RRESP, BRESP};
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
    end
  end

  // Stall must see a new request in IDLE the same cycle it appears.
  assign mem_stall   = (state_q == IDLE) ? (mem_re || mem_we) : (state_q != DONE);
  assign mem_rdata   = rdata_q;
  assign mem_bus_err = err_q;

  assign ARID    = ID_VAL;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARADDR  = addr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign AWID    = ID_VAL;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWADDR  = addr_q;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WVALID  = wvalid_q;
  assign WLAST   = wvalid_q;
  assign BREADY  = bready_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Bench for mem_axi_master: handshake-level model checked every cycle plus directed literal checks.
module tb_mem_axi_master;
`ifdef MEM_AXI_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        mem_re = 0, mem_we = 0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_bus_err;
  logic [3:0]  ARID, AWID;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY = 0, RVALID = 0, AWREADY = 0, WREADY = 0, BVALID = 0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;

  int n_checks = 0, n_errors = 0;

  mem_axi_master #(.ID_VAL(4'h1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_bus_err(mem_bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Transaction-level model: one outstanding request, tracked by which handshakes have happened.
  bit          m_active, m_wr, m_ar_done, m_aw_done, m_w_done, m_done, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always @(negedge ACLK) begin
    bit e_ar, e_r, e_aw, e_w, e_b, e_stall;
    if (!ARESETn) begin
      m_active = 0; m_done = 0; m_err = 0; m_rdata = '0;
      m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
      chk("rst_arvalid", {31'd0, ARVALID}, 0);
      chk("rst_awvalid", {31'd0, AWVALID}, 0);
      chk("rst_wvalid",  {31'd0, WVALID}, 0);
      chk("rst_rready",  {31'd0, RREADY}, 0);
      chk("rst_bready",  {31'd0, BREADY}, 0);
      chk("rst_rdata",   mem_rdata, 0);
      chk("rst_err",     {31'd0, mem_bus_err}, 0);
      chk("rst_stall",   {31'd0, mem_stall}, {31'd0, mem_re | mem_we});
    end else begin
      e_ar    = m_active && !m_wr && !m_ar_done;
      e_r     = m_active && !m_wr && m_ar_done;
      e_aw    = m_active && m_wr && !m_aw_done;
      e_w     = m_active && m_wr && !m_w_done;
      e_b     = m_active && m_wr && m_aw_done && m_w_done;
      e_stall = m_active || (!m_done && (mem_re || mem_we));
      chk("m_arvalid", {31'd0, ARVALID}, {31'd0, e_ar});
      chk("m_rready",  {31'd0, RREADY},  {31'd0, e_r});
      chk("m_awvalid", {31'd0, AWVALID}, {31'd0, e_aw});
      chk("m_wvalid",  {31'd0, WVALID},  {31'd0, e_w});
      chk("m_wlast",   {31'd0, WLAST},   {31'd0, e_w});
      chk("m_bready",  {31'd0, BREADY},  {31'd0, e_b});
      chk("m_stall",   {31'd0, mem_stall}, {31'd0, e_stall});
      chk("m_rdata",   mem_rdata, m_rdata);
      chk("m_err",     {31'd0, mem_bus_err}, {31'd0, m_err});
      if (e_ar) chk("m_araddr", ARADDR, m_addr);
      if (e_aw) chk("m_awaddr", AWADDR, m_addr);
      if (e_w) begin
        chk("m_wdata", WDATA, m_wdata);
        chk("m_wstrb", {28'd0, WSTRB}, {28'd0, m_wstrb});
      end
      if (m_done) m_done = 0;
      else if (!m_active) begin
        if (mem_we || mem_re) begin
          m_active = 1; m_wr = mem_we; m_addr = mem_addr;
          m_wdata = mem_wdata; m_wstrb = mem_wstrb;
          m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
        end
      end else begin
        if (e_ar && ARREADY) m_ar_done = 1;
        if (e_aw && AWREADY) m_aw_done = 1;
        if (e_w && WREADY)   m_w_done = 1;
        if (e_r && RVALID) begin
          m_rdata = RDATA;
          if (ERR_ON && RRESP != 2'b00) m_err = 1;
          m_active = 0; m_done = 1;
        end
        if (e_b && BVALID) begin
          if (ERR_ON && BRESP != 2'b00) m_err = 1;
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("arid",    {28'd0, ARID}, 32'h1);
    chk("awid",    {28'd0, AWID}, 32'h1);
    chk("arlen",   {24'd0, ARLEN}, 0);
    chk("awlen",   {24'd0, AWLEN}, 0);
    chk("arsize",  {29'd0, ARSIZE}, 2);
    chk("awsize",  {29'd0, AWSIZE}, 2);
    chk("arburst", {30'd0, ARBURST}, 1);
    chk("awburst", {30'd0, AWBURST}, 1);
    chk("idle_stall", {31'd0, mem_stall}, 0);

    // Load at minimum latency.
    cyc();
    mem_re = 1; mem_addr = 32'h0000_1004; ARREADY = 1;
    @(negedge ACLK); chk("ld_stall_n", {31'd0, mem_stall}, 1);
    cyc();
    @(negedge ACLK); chk("ld_arvalid_n1", {31'd0, ARVALID}, 1);
    chk("ld_araddr_n1", ARADDR, 32'h0000_1004);
    chk("ld_stall_n1", {31'd0, mem_stall}, 1);
    cyc();
    RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
    @(negedge ACLK); chk("ld_rready_n2", {31'd0, RREADY}, 1);
    chk("ld_stall_n2", {31'd0, mem_stall}, 1);
    cyc();
    RVALID = 0; RDATA = '0; mem_re = 0; ARREADY = 0;
    @(negedge ACLK); chk("ld_rdata_n3", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_stall_n3", {31'd0, mem_stall}, 0);
    cyc();

    // Store with staggered AW/W/B acceptance.
    mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'h1234_5678; mem_wstrb = 4'hF;
    @(negedge ACLK); chk("st_stall_s", {31'd0, mem_stall}, 1);
    cyc();
    AWREADY = 1;
    @(negedge ACLK); chk("st_awvalid_s1", {31'd0, AWVALID}, 1);
    chk("st_wvalid_s1", {31'd0, WVALID}, 1);
    chk("st_wdata_s1", WDATA, 32'h1234_5678);
    cyc();
    AWREADY = 0;
    @(negedge ACLK); chk("st_awvalid_s2", {31'd0, AWVALID}, 0);
    chk("st_wvalid_s2", {31'd0, WVALID}, 1);
    cyc();
    WREADY = 1;
    @(negedge ACLK); chk("st_wvalid_s3", {31'd0, WVALID}, 1);
    cyc();
    WREADY = 0;
    @(negedge ACLK); chk("st_wvalid_s4", {31'd0, WVALID}, 0);
    chk("st_bready_s4", {31'd0, BREADY}, 1);
    cyc();
    BVALID = 1; BRESP = 2'b00;
    @(negedge ACLK); chk("st_stall_s5", {31'd0, mem_stall}, 1);
    cyc();
    BVALID = 0; mem_we = 0;
    @(negedge ACLK); chk("st_stall_s6", {31'd0, mem_stall}, 0);
    chk("st_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    cyc();

    // Both requests: write wins; same-cycle AW/W handshake; error response.
    mem_re = 1; mem_we = 1; mem_addr = 32'h3000; mem_wdata = 32'hA5A5_A5A5; mem_wstrb = 4'h3;
    AWREADY = 1; WREADY = 1;
    cyc();
    @(negedge ACLK); chk("both_arvalid", {31'd0, ARVALID}, 0);
    chk("both_awvalid", {31'd0, AWVALID}, 1);
    cyc();
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b10;
    @(negedge ACLK); chk("both_bready", {31'd0, BREADY}, 1);
    cyc();
    BVALID = 0; BRESP = 2'b00; mem_re = 0; mem_we = 0;
    @(negedge ACLK); chk("both_stall_done", {31'd0, mem_stall}, 0);
    chk("both_err", {31'd0, mem_bus_err}, {31'd0, ERR_ON});
    cyc();

    // ARREADY held off for 10 cycles.
    mem_re = 1; mem_addr = 32'h0000_4440;
    cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK); chk("ar_wait_valid", {31'd0, ARVALID}, 1);
      chk("ar_wait_addr", ARADDR, 32'h0000_4440);
      chk("ar_wait_stall", {31'd0, mem_stall}, 1);
      cyc();
    end
    ARREADY = 1;
    cyc();
    ARREADY = 0; RVALID = 1; RDATA = 32'hCAFE_F00D;
    cyc();
    RVALID = 0; mem_re = 0;
    @(negedge ACLK); chk("ar_wait_rdata", mem_rdata, 32'hCAFE_F00D);
    cyc();

    // Reset mid-WREQ.
    mem_we = 1; mem_addr = 32'h5000; mem_wdata = 32'h1; mem_wstrb = 4'h1;
    cyc();
    @(negedge ACLK); chk("wreq_awvalid", {31'd0, AWVALID}, 1);
    cyc();
    ARESETn = 0; mem_we = 0;
    @(negedge ACLK); chk("midrst_awvalid", {31'd0, AWVALID}, 0);
    chk("midrst_wvalid", {31'd0, WVALID}, 0);
    chk("midrst_rdata", mem_rdata, 0);
    cyc();
    ARESETn = 1;
    cyc();
    // Load after reset, error RRESP.
    mem_re = 1; mem_addr = 32'h6000; ARREADY = 1;
    cyc();
    @(negedge ACLK); chk("post_rst_arvalid", {31'd0, ARVALID}, 1);
    cyc();
    ARREADY = 0; RVALID = 1; RDATA = 32'h0BAD_F00D; RRESP = 2'b10;
    cyc();
    RVALID = 0; RRESP = 2'b00; mem_re = 0;
    @(negedge ACLK); chk("post_rst_rdata", mem_rdata, 32'h0BAD_F00D);
    chk("post_rst_err", {31'd0, mem_bus_err}, {31'd0, ERR_ON});
    chk("post_rst_stall", {31'd0, mem_stall}, 0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
